// File: rtl/sound_mixer_pkg.sv
// Shared types and gain tables for the sound mixer datapath.
// Gain factors are expressed in sixteenths of unity.
package sound_mixer_pkg;

  localparam int GAIN_FRAC_BITS = 4;
  localparam int FACTOR_W       = 6;

  typedef logic signed [3:0] gain_code_t;

  localparam logic [FACTOR_W-1:0] GAIN_LUT [16] = '{
    6'd0,  6'd7,  6'd8,  6'd9,  6'd10, 6'd11, 6'd13, 6'd14,
    6'd16, 6'd18, 6'd20, 6'd23, 6'd26, 6'd29, 6'd32, 6'd36
  };

  // Flipping the sign bit turns code -8..7 into table index 0..15.
  function automatic logic [FACTOR_W-1:0] gain_factor(input gain_code_t code);
    return GAIN_LUT[{~code[3], code[2:0]}];
  endfunction

endpackage

// File: rtl/gain_ramp_ctrl.sv
// Per-channel gain ramp state: target code, current code and step counter.
// The current code walks one step toward the target every STEP_SAMPLES samples.
module gain_ramp_ctrl
  import sound_mixer_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int STEP_SAMPLES = 32,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            gain_we,
  input  logic [CH_W-1:0] gain_ch,
  input  gain_code_t      gain_code,
  input  logic            step_en,
  input  logic [CH_W-1:0] step_ch,
  output gain_code_t      cur_code
);

  localparam int CNT_W = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_SAMPLES - 1);

  gain_code_t       target [CHANNELS];
  gain_code_t       cur    [CHANNELS];
  logic [CNT_W-1:0] cnt    [CHANNELS];

  // The target write lands after the step decision, so a same-cycle write
  // only influences later samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        target[c] <= '0;
        cur[c]    <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (step_en && int'(step_ch) == c) begin
          if (cur[c] == target[c]) begin
            cnt[c] <= '0;
          end else if (cnt[c] == CNT_LAST) begin
            cnt[c] <= '0;
            cur[c] <= (cur[c] < target[c]) ? cur[c] + 4'sd1 : cur[c] - 4'sd1;
          end else begin
            cnt[c] <= cnt[c] + 1'b1;
          end
        end
        if (gain_we && int'(gain_ch) == c) target[c] <= gain_code;
      end
    end
  end

  always_comb begin
    cur_code = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(step_ch) == c) cur_code = cur[c];
    end
  end

endmodule

// File: rtl/gain_ramp_amplifier.sv
// Time-multiplexed ramped gain stage: two-stage multiply/round/saturate pipeline
// with valid/ready handshakes and sticky per-channel clip flags.
module gain_ramp_amplifier
  import sound_mixer_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 2,
  parameter int STEP_SAMPLES = 32,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    gain_we,
  input  logic [CH_W-1:0]         gain_ch,
  input  gain_code_t              gain_code,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]     clip,
  input  logic                    clip_clr
);

  localparam int PROD_W = WIDTH + FACTOR_W;
  localparam int RND_W  = PROD_W - GAIN_FRAC_BITS;
  localparam logic signed [WIDTH+1:0] MAX_V = $signed({3'b000, {(WIDTH-1){1'b1}}});
  localparam logic signed [WIDTH+1:0] MIN_V = $signed({3'b111, {(WIDTH-1){1'b0}}});

  // Round half toward +inf: add half an LSB of the fraction, then drop it.
  function automatic logic signed [RND_W-1:0] round_half_up(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] biased;
    biased = prod + $signed(PROD_W'(1 << (GAIN_FRAC_BITS - 1)));
    return biased[PROD_W-1:GAIN_FRAC_BITS];
  endfunction

  function automatic logic overflows(input logic signed [RND_W-1:0] x);
    return (x > MAX_V) || (x < MIN_V);
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [RND_W-1:0] x);
    if (x > MAX_V)      return MAX_V[WIDTH-1:0];
    else if (x < MIN_V) return MIN_V[WIDTH-1:0];
    else                return x[WIDTH-1:0];
  endfunction

  logic                     adv;
  logic                     accept;
  logic                     ch_ok;
  gain_code_t               cur_code;

  logic                     vld_p1;
  logic [CH_W-1:0]          ch_p1;
  logic signed [WIDTH-1:0]  data_p1;
  logic signed [FACTOR_W:0] factor_p1;

  logic signed [PROD_W-1:0] prod_p1;
  logic signed [RND_W-1:0]  rounded_p1;
  logic                     clip_hit_p1;
  logic [CHANNELS-1:0]      clip_set;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign ch_ok    = int'(in_ch) < CHANNELS;

  gain_ramp_ctrl #(
    .CHANNELS     (CHANNELS),
    .STEP_SAMPLES (STEP_SAMPLES),
    .CH_W         (CH_W)
  ) u_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .gain_we   (gain_we),
    .gain_ch   (gain_ch),
    .gain_code (gain_code),
    .step_en   (accept && ch_ok),
    .step_ch   (in_ch),
    .cur_code  (cur_code)
  );

  // ---- Stage 1: capture sample and the factor of the pre-update gain code ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= accept;
  end

  // Out-of-range channels get a zero factor, which yields 0 and can never clip.
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_p1     <= in_ch;
      data_p1   <= in_data;
      factor_p1 <= ch_ok ? $signed({1'b0, gain_factor(cur_code)}) : '0;
    end
  end

  // ---- Stage 2: multiply, round, saturate and flag clipping ----
  assign prod_p1     = PROD_W'(data_p1) * PROD_W'(factor_p1);
  assign rounded_p1  = round_half_up(prod_p1);
  assign clip_hit_p1 = overflows(rounded_p1);

  always_comb begin
    clip_set = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (adv && vld_p1 && clip_hit_p1 && int'(ch_p1) == c) clip_set[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      clip      <= '0;
    end else begin
      if (adv) begin
        out_valid <= vld_p1;
        if (vld_p1) begin
          out_ch   <= ch_p1;
          out_data <= saturate(rounded_p1);
        end
      end
      clip <= (clip & ~{CHANNELS{clip_clr}}) | clip_set;
    end
  end

endmodule

// File: tb/tb_gain_ramp_amplifier.sv
// Randomized and directed bench for gain_ramp_amplifier against a behavioural
// model of the gain/ramp rules and an in-order output scoreboard.
module tb_gain_ramp_amplifier;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 2;
  localparam int STEP     = 4;
  localparam int CH_W     = 1;
  localparam int NONE     = 32'h7fffffff;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    gain_we = 1'b0;
  logic [CH_W-1:0]         gain_ch = '0;
  logic signed [3:0]       gain_code = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch = '0;
  logic signed [WIDTH-1:0] in_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]     clip;
  logic                    clip_clr = 1'b0;

  always #5 clk = ~clk;

  gain_ramp_amplifier #(
    .WIDTH        (WIDTH),
    .CHANNELS     (CHANNELS),
    .STEP_SAMPLES (STEP),
    .CH_W         (CH_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gain_we   (gain_we),
    .gain_ch   (gain_ch),
    .gain_code (gain_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .clip      (clip),
    .clip_clr  (clip_clr)
  );

  typedef struct {
    int ch;
    int data;
    int want;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tgt[CHANNELS];
  int   cur[CHANNELS];
  int   cnt[CHANNELS];
  int   clip_exp = 0;
  bit   stalled_prev = 1'b0;
  bit   last_acc = 1'b0;
  int   held_data = 0;
  int   held_ch = 0;
  int   factor_tab[16] = '{0, 7, 8, 9, 10, 11, 13, 14, 16, 18, 20, 23, 26, 29, 32, 36};
  int   ramp_want[9]  = '{1600, 1400, 1300, 1100, 1000, 900, 800, 700, 0};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < CHANNELS; c++) begin
      tgt[c] = 0;
      cur[c] = 0;
      cnt[c] = 0;
    end
    clip_exp     = 0;
    stalled_prev = 1'b0;
  endtask

  task automatic model_accept(input int ch, input int data, input int want);
    exp_t e;
    int   r;
    e.ch   = ch;
    e.want = want;
    if (ch >= CHANNELS) begin
      e.data = 0;
    end else begin
      r = (data * factor_tab[cur[ch] + 8] + 8) >>> 4;
      if (r > 32767) begin
        r = 32767;
        clip_exp |= (1 << ch);
      end else if (r < -32768) begin
        r = -32768;
        clip_exp |= (1 << ch);
      end
      e.data = r;
      if (cur[ch] == tgt[ch]) cnt[ch] = 0;
      else if (cnt[ch] == STEP - 1) begin
        cnt[ch] = 0;
        cur[ch] += (tgt[ch] > cur[ch]) ? 1 : -1;
      end else cnt[ch]++;
    end
    q.push_back(e);
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later,
  // account for what the next rising edge will transfer.
  task automatic step(input bit iv, input int ich, input int idata, input bit ordy, input int want);
    exp_t e;
    in_valid  = iv;
    in_ch     = ich[CH_W-1:0];
    in_data   = idata[WIDTH-1:0];
    out_ready = ordy;
    #1;
    if (stalled_prev) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), held_data);
      check("stall_ch", int'(out_ch), held_ch);
    end
    if (out_valid && !out_ready) check("stall_in_ready", int'(in_ready), 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("out_unexpected", q.size(), 1);
      else begin
        e = q.pop_front();
        check("out_data", int'(out_data), e.data);
        check("out_ch", int'(out_ch), e.ch);
        if (e.want != NONE) check("out_literal", int'(out_data), e.want);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) model_accept(ich, idata, want);
    if (gain_we && int'(gain_ch) < CHANNELS) tgt[gain_ch] = int'(gain_code);
    stalled_prev = out_valid && !out_ready;
    held_data    = int'(out_data);
    held_ch      = int'(out_ch);
    @(negedge clk);
    gain_we  = 1'b0;
    clip_clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b1, NONE);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) idle();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic set_gain(input int ch, input int code);
    gain_we   = 1'b1;
    gain_ch   = ch[CH_W-1:0];
    gain_code = code[3:0];
    idle();
  endtask

  task automatic settle(input int ch);
    for (int i = 0; i < 80 && cur[ch] != tgt[ch]; i++) step(1'b1, ch, 0, 1'b1, NONE);
  endtask

  initial begin
    int idx;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unity gain and two-cycle latency
    step(1'b1, 0, 1000, 1'b1, 1000);
    check("lat_c1_valid", int'(out_valid), 0);
    idle();
    check("lat_c2_valid", int'(out_valid), 1);
    check("lat_c2_data", int'(out_data), 1000);
    drain();
    check("unity_clip", int'(clip), 0);

    // Rounding corners
    set_gain(0, -7); settle(0); step(1'b1, 0, -3, 1'b1, -1);
    set_gain(0, -1); settle(0); step(1'b1, 0, 8, 1'b1, 7);
    set_gain(0, -8); settle(0); step(1'b1, 0, -32768, 1'b1, 0);
    drain();

    // Saturation and sticky clip
    set_gain(1, 7); settle(1);
    step(1'b1, 1, 20000, 1'b1, 32767);
    step(1'b1, 1, -20000, 1'b1, -32768);
    drain();
    check("clip_model", int'(clip), clip_exp);
    check("clip_sat", int'(clip), 2);
    clip_clr = 1'b1;
    idle();
    clip_exp = 0;
    check("clip_clr", int'(clip), 0);
    step(1'b1, 1, 20000, 1'b1, 32767);
    clip_clr = 1'b1;
    idle();
    check("clip_set_wins", int'(clip), 2);
    drain();

    // Ramp from unity to mute, interleaved with a unity channel
    set_gain(1, 0); settle(1);
    set_gain(0, 0); settle(0);
    drain();
    set_gain(0, -8);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 0, 1600, 1'b1, ramp_want[(k / 4 > 8) ? 8 : k / 4]);
      step(1'b1, 1, 1600, 1'b1, 1600);
    end
    drain();

    // Backpressure: five stalled cycles mid-stream
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(idx < 14, 1, 100 * (idx + 1), !(cyc >= 4 && cyc < 9), NONE);
      if (last_acc) idx++;
    end
    drain();
    check("bp_all_sent", idx, 14);

    // Randomized traffic with random stalls and gain changes
    clip_clr = 1'b1;
    idle();
    clip_exp = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        gain_we   = 1'b1;
        gain_ch   = CH_W'($urandom_range(0, CHANNELS - 1));
        gain_code = 4'($urandom);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, CHANNELS - 1),
           int'($signed(16'($urandom))), $urandom_range(0, 3) != 0, NONE);
    end
    drain();
    check("rand_clip", int'(clip), clip_exp);

    // Asynchronous reset in the middle of a ramp and a stall
    set_gain(0, 3);
    for (int i = 0; i < 6; i++) step(1'b1, 0, 500, 1'b1, NONE);
    step(1'b1, 0, 700, 1'b0, NONE);
    step(1'b1, 0, 700, 1'b0, NONE);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_ch", int'(out_ch), 0);
    check("mid_rst_clip", int'(clip), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) step(1'b1, 0, 1000, 1'b1, 1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
